// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx between two byte requesters. A byte is accepted from the
// selected requester while idle, registered onto tx_data, and announced to the
// UART with a one-cycle tx_start. The arbiter then waits for the UART to raise
// and drop tx_busy before accepting the next byte. With LOCK_EN=1 a requester
// keeps the grant from its first byte until it sends a byte flagged last.
//
// Parameters
//   LOCK_EN       1: hold the grant for a whole message, 0: arbitrate per byte
//   BUSY_TIMEOUT  cycles to wait for tx_busy to rise after tx_start (>= 1)
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   s0_* / s1_*         requester byte handshake (valid, data, last, ready)
//   tx_start, tx_data   start pulse and byte to uart_tx
//   tx_busy             busy flag from uart_tx
//   grant               one-hot owner of the current or last transfer
//   busy                high whenever the arbiter is not idle
//   err                 one-cycle pulse when tx_busy never rose
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter bit LOCK_EN      = 1'b1,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam int               CNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    logic [1:0]       state;
    logic             locked;
    logic             lock_owner;   // 0 = s0, 1 = s1
    logic             last_grant;   // requester served most recently
    logic [CNT_W-1:0] tmo_cnt;

    logic [1:0] s_valid;
    logic       sel;                // requester chosen this cycle
    logic       sel_ok;             // chosen requester has a byte
    logic       xfer;

    assign s_valid = {s1_valid, s0_valid};

    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sel    = 1'b0;
        sel_ok = 1'b0;
        if (locked) begin
            // Only the lock owner may be served, however long it stays idle.
            sel    = lock_owner;
            sel_ok = s_valid[lock_owner];
        end else if (s0_valid && s1_valid) begin
            // Round robin: the requester not served last goes first.
            sel    = ~last_grant;
            sel_ok = 1'b1;
        end else if (s0_valid) begin
            sel    = 1'b0;
            sel_ok = 1'b1;
        end else if (s1_valid) begin
            sel    = 1'b1;
            sel_ok = 1'b1;
        end
    end

    assign s0_ready = (state == IDLE) && sel_ok && !sel && s0_valid;
    assign s1_ready = (state == IDLE) && sel_ok &&  sel && s1_valid;
    assign xfer     = s0_ready || s1_ready;

    assign tx_start = (state == START);
    assign busy     = (state != IDLE);

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_data    <= 8'h00;
            grant      <= 2'b00;
            err        <= 1'b0;
            locked     <= 1'b0;
            lock_owner <= 1'b0;
            last_grant <= 1'b1;     // makes s0 the first winner after reset
            tmo_cnt    <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        tx_data    <= sel ? s1_data : s0_data;
                        grant      <= sel ? 2'b10 : 2'b01;
                        last_grant <= sel;
                        if (LOCK_EN) begin
                            // A byte without last opens (or keeps) the lock;
                            // a byte with last releases it.
                            locked     <= !(sel ? s1_last : s0_last);
                            lock_owner <= sel;
                        end
                        state <= START;
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        // The UART never answered: report it, drop any lock so
                        // the other requester is not starved, and move on.
                        err    <= 1'b1;
                        locked <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Runs two arbiters side by side on identical stimulus: inst[0] with
// LOCK_EN=1 and inst[1] with LOCK_EN=0. Each phase loads byte queues for both
// requesters; requesters hold valid while they have bytes, so the transmit
// order follows from message-level round-robin/lock rules, which the load task
// computes into an expected queue per instance. Monitors pop and compare on
// every tx_start; a small UART model answers tx_start with randomised tx_busy.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int BT = 15;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    bit   tie_low   = 1'b0;   // UART never raises tx_busy
    bit   long_busy = 1'b0;   // UART answers at once and stays busy long
    bit   rst_test  = 1'b0;   // suppress UART-side checks across a reset

    logic [8:0] src_q [4][$];   // {last, data}, index 2*inst + requester
    logic [8:0] exp_q [2][$];   // {requester, data} in transmit order
    logic [8:0] stg0[$], stg1[$];
    int         start_cnt [2];
    int         last_start[2];
    int         err_cnt   [2];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        logic       s0_valid, s1_valid, s0_last, s1_last, s0_ready, s1_ready;
        logic [7:0] s0_data, s1_data, tx_data;
        logic       tx_start, tx_busy, busy, err;
        logic [1:0] grant;
        int         acc_cyc = 0;

        uart_tx_arbiter #(.LOCK_EN(g == 0), .BUSY_TIMEOUT(BT)) dut (
            .clk(clk), .rst(rst),
            .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
            .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
            .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
            .grant(grant), .busy(busy), .err(err)
        );

        // Requesters: present the head of their queue, pop it once accepted.
        initial begin
            bit take0, take1;
            logic [8:0] h;
            s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
            s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
            forever begin
                @(negedge clk);
                take0 = s0_ready && s0_valid;
                take1 = s1_ready && s1_valid;
                if (take0 || take1) acc_cyc = cyc;
                @(posedge clk);
                #1;
                if (!rst && take0 && src_q[2*g].size() > 0)   void'(src_q[2*g].pop_front());
                if (!rst && take1 && src_q[2*g+1].size() > 0) void'(src_q[2*g+1].pop_front());
                s0_valid = (src_q[2*g].size() > 0);
                if (s0_valid) begin
                    h = src_q[2*g][0];
                    s0_data = h[7:0]; s0_last = h[8];
                end
                s1_valid = (src_q[2*g+1].size() > 0);
                if (s1_valid) begin
                    h = src_q[2*g+1][0];
                    s1_data = h[7:0]; s1_last = h[8];
                end
            end
        end

        // UART model: rises 0..3 cycles after tx_start, stays busy 2..5 cycles.
        initial begin
            tx_busy = 1'b0;
            forever begin
                @(negedge clk);
                if (tx_start && !tie_low) begin
                    int d, l;
                    d = long_busy ? 0 : $urandom_range(3, 0);
                    l = long_busy ? 12 : $urandom_range(5, 2);
                    repeat (d) @(negedge clk);
                    tx_busy = 1'b1;
                    repeat (l) @(negedge clk);
                    tx_busy = 1'b0;
                    if (!rst_test) check($sformatf("i%0d_busy_at_fall", g), busy, 1);
                    @(negedge clk);
                    if (!rst_test) check($sformatf("i%0d_busy_after_fall", g), busy, 0);
                end
            end
        end

        // Monitor: scoreboard compare on each tx_start, plus per-cycle rules.
        initial begin
            logic [8:0] e;
            logic [7:0] held;
            held = 8'h00;
            forever begin
                @(negedge clk);
                check($sformatf("i%0d_ready_exclusive", g), s0_ready & s1_ready, 0);
                if (tx_start) begin
                    start_cnt[g]++;
                    last_start[g] = cyc;
                    check($sformatf("i%0d_ready_to_start", g), cyc, acc_cyc + 1);
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL i%0d_unexpected_start actual tx_data=%h required no tx_start", g, tx_data);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("i%0d_tx_data", g), tx_data, e[7:0]);
                        check($sformatf("i%0d_grant", g), grant, e[8] ? 2 : 1);
                    end
                    held = tx_data;
                end else if (busy) begin
                    check($sformatf("i%0d_tx_data_hold", g), tx_data, held);
                end
                if (err) begin
                    err_cnt[g]++;
                    check($sformatf("i%0d_err_expected", g), tie_low, 1);
                    check($sformatf("i%0d_err_delay", g), cyc - last_start[g], BT + 1);
                    check($sformatf("i%0d_busy_at_err", g), busy, 0);
                end
            end
        end

        // Reset values must appear without any clock edge.
        initial forever begin
            @(posedge rst);
            #1;
            check($sformatf("i%0d_rst_tx_start", g), tx_start, 0);
            check($sformatf("i%0d_rst_tx_data", g), tx_data, 0);
            check($sformatf("i%0d_rst_grant", g), grant, 0);
            check($sformatf("i%0d_rst_busy", g), busy, 0);
            check($sformatf("i%0d_rst_err", g), err, 0);
        end
    end

    task automatic push(input int r, input logic [7:0] d, input bit l);
        if (r == 0) stg0.push_back({l, d});
        else        stg1.push_back({l, d});
    endtask

    // Hand the staged messages to both instances and predict transmit order
    // from the arbitration rules, assuming a freshly reset arbiter.
    task automatic load();
        for (int g = 0; g < 2; g++) begin
            logic [8:0] a[$], b[$], e;
            int  lg, own, i;
            bit  lk;
            a = stg0; b = stg1;
            lg = 1; lk = 1'b0; own = 0;
            foreach (stg0[k]) src_q[2*g].push_back(stg0[k]);
            foreach (stg1[k]) src_q[2*g+1].push_back(stg1[k]);
            while (a.size() > 0 || b.size() > 0) begin
                if (lk)                              i = own;
                else if (a.size() > 0 && b.size() > 0) i = 1 - lg;
                else                                 i = (a.size() > 0) ? 0 : 1;
                if (lk && ((i == 0) ? a.size() : b.size()) == 0) break;
                e = (i == 0) ? a.pop_front() : b.pop_front();
                exp_q[g].push_back({i[0], e[7:0]});
                lg = i;
                if (g == 0 && !tie_low) begin
                    lk  = !e[8];
                    own = i;
                end
            end
        end
        stg0.delete();
        stg1.delete();
    endtask

    function automatic bit all_idle();
        return exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
               src_q[0].size() == 0 && src_q[1].size() == 0 &&
               src_q[2].size() == 0 && src_q[3].size() == 0 &&
               !inst[0].busy && !inst[1].busy;
    endfunction

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (!all_idle() && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s_drain actual pending %0d/%0d bytes after %0d cycles required 0/0",
                     name, exp_q[0].size(), exp_q[1].size(), limit);
            for (int k = 0; k < 4; k++) src_q[k].delete();
            exp_q[0].delete();
            exp_q[1].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual time limit reached required finish");
        $fatal(1);
    end

    initial begin
        int s0c, s1c, n;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single byte from s0.
        push(0, 8'h55, 1'b1);
        load();
        drain("single", 200);

        // Contention: both always valid with one-byte messages.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(0, "A", 1'b1);
            push(1, "B", 1'b1);
        end
        load();
        drain("contention", 400);

        // Locked message "UART" against a pending 'x'.
        do_reset();
        push(0, "U", 1'b0); push(0, "A", 1'b0); push(0, "R", 1'b0); push(0, "T", 1'b1);
        push(1, "x", 1'b1);
        load();
        drain("lock", 400);

        // Random messages on both requesters.
        for (int rnd = 0; rnd < 8; rnd++) begin
            do_reset();
            for (int r = 0; r < 2; r++) begin
                int nm, len;
                nm = $urandom_range(3, (r == 0) ? 1 : 0);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(4, 1);
                    for (int k = 0; k < len; k++)
                        push(r, 8'($urandom_range(255, 0)), k == len - 1);
                end
            end
            load();
            drain("random", 1500);
        end

        // Timeout: UART silent. The timeout must also release s0's lock.
        do_reset();
        tie_low = 1'b1;
        err_cnt[0] = 0;
        err_cnt[1] = 0;
        push(0, "A", 1'b0); push(0, "B", 1'b1);
        push(1, "x", 1'b1);
        load();
        drain("timeout", 400);
        check("i0_timeout_err_count", err_cnt[0], 3);
        check("i1_timeout_err_count", err_cnt[1], 3);
        tie_low = 1'b0;

        // Reset while waiting for the UART to finish a locking byte.
        do_reset();
        long_busy = 1'b1;
        push(0, "m", 1'b0);
        load();
        n = 0;
        while (!(inst[0].tx_busy && inst[1].tx_busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_tx_busy", n < 50, 1);
        repeat (2) @(negedge clk);
        check("i0_in_wait_done", inst[0].busy, 1);
        rst_test = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s0c = start_cnt[0];
        s1c = start_cnt[1];
        repeat (20) @(negedge clk);
        check("i0_no_start_after_rst", start_cnt[0] - s0c, 0);
        check("i1_no_start_after_rst", start_cnt[1] - s1c, 0);
        rst_test  = 1'b0;
        long_busy = 1'b0;
        push(1, "n", 1'b1);
        load();
        drain("after_reset", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter LOCK_EN, default 1: 1 = a requester keeps the grant until it sends a byte with last=1; 0 = arbitrate on every byte.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 15: maximum cycles to wait for tx_busy to rise after tx_start.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s0_valid / s1_valid  in  1 each  requester byte valid.
REQ-006 SHALL have ports s0_data / s1_data  in  8 each  requester byte.
REQ-007 SHALL have ports s0_last / s1_last  in  1 each  byte ends the requester's message.
REQ-008 SHALL have ports s0_ready / s1_ready  out  1 each  byte accepted this cycle when ready and valid are both high.
REQ-009 SHALL have port tx_start  out  1  one-cycle start pulse to uart_tx.
REQ-010 SHALL have port tx_data  out  8  byte to uart_tx; registered.
REQ-011 SHALL have port tx_busy  in  1  busy flag from uart_tx.
REQ-012 SHALL have port grant  out  2  one-hot owner of the current or last transfer.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port err  out  1  one-cycle pulse on busy timeout.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-016 SHALL select in IDLE as follows: if locked, only the lock owner may be selected; otherwise round-robin among the valid requesters, with the requester not granted last taking priority.
REQ-017 SHALL drive s_ready[i] combinationally as (state==IDLE) && selected==i && s_valid[i]; at most one ready SHALL be high in any cycle.
REQ-018 SHALL, on a transfer in cycle T, register tx_data <= s_data, set grant to the one-hot of i, record i as last-granted, and enter START.
REQ-019 SHALL, in START, drive tx_start=1 for exactly one cycle (cycle T+1) and then enter WAIT_BUSY.
REQ-020 SHALL, in WAIT_BUSY, enter WAIT_DONE when tx_busy=1.
REQ-021 SHALL, in WAIT_BUSY, pulse err and return to IDLE if tx_busy has not risen after BUSY_TIMEOUT cycles; the timeout SHALL clear the lock.
REQ-022 SHALL, in WAIT_DONE, return to IDLE when tx_busy=0; the earliest next ready is therefore the cycle after tx_busy falls.
REQ-023 SHALL, when LOCK_EN=1, set the lock to the transferring requester on a transfer with last=0 and clear it on a transfer with last=1.
REQ-024 SHALL, when LOCK_EN=0, never set the lock.
REQ-025 SHALL, while locked, leave the other requester's ready low even if it is valid; no timeout SHALL apply while the owner is idle.
REQ-026 SHALL, when both requesters are valid with no lock and no prior grant, grant s0 first.
REQ-027 SHALL ignore tx_busy in IDLE and START.
REQ-028 SHALL hold tx_data stable from START until the FSM returns to IDLE.

Reset
REQ-029 SHALL, while rst is high, asynchronously force: state=IDLE, tx_start=0, tx_data=8'h00, grant=2'b00, busy=0, err=0, lock cleared, last-granted=s1 (so s0 wins first), timeout counter=0.
REQ-030 SHALL, on reset asserted mid-byte, abort the transfer, drop the lock, and not re-send the byte after reset release.

Verification
REQ-031 SHALL cover single byte: s0 sends 8'h55 with last=1 -> s0_ready in cycle T, tx_start in T+1, tx_data=8'h55, busy falls the cycle after tx_busy falls.
REQ-032 SHALL cover contention: s0 and s1 both continuously valid with last=1 (bytes 'A' and 'B') -> transmit order A, B, A, B; grant alternates 01, 10.
REQ-033 SHALL cover lock (LOCK_EN=1): s0 sends "UART" with last on 'T' while s1 is valid with 'x' -> "UART" sent contiguously, then 'x'.
REQ-034 SHALL cover no lock (LOCK_EN=0): same stimulus as REQ-033 -> bytes interleave U, x, A, ...
REQ-035 SHALL cover timeout: tx_busy tied low -> err pulses after BUSY_TIMEOUT cycles in WAIT_BUSY, state returns to IDLE, and the next requester is served.
REQ-036 SHALL cover reset in WAIT_DONE: rst asserted -> all outputs reach reset values with no clock edge needed; after release, no tx_start occurs until a new valid arrives.
